// File: rtl/core_mem_arbiter.sv
// Core memory arbiter: funnels N_REQ core-internal requesters onto one shared
// memory port and routes responses back using the source id in the low packet bits.
module core_mem_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned PKT_W   = 64,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*PKT_W-1:0] i_req_pkt,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_out_req_valid,
  output logic [PKT_W-1:0]       o_out_req_pkt,
  input  logic                   i_out_req_ready,
  input  logic                   i_out_rsp_valid,
  input  logic [PKT_W-1:0]       i_out_rsp_pkt,
  output logic                   o_out_rsp_ready,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [PKT_W-1:0]       o_rsp_pkt,
  input  logic [N_REQ-1:0]       i_rsp_ready,
  output logic [3:0]             o_outstanding,
  output logic                   o_err_unrouted
);

  typedef enum logic {StIdle, StSend} req_state_e;
  typedef enum logic {StRIdle, StRHold} rsp_state_e;

  req_state_e        r_req_state, w_req_state_next;
  rsp_state_e        r_rsp_state, w_rsp_state_next;

  logic [ID_W-1:0]   r_last_grant;
  logic [PKT_W-1:0]  r_req_pkt;
  logic [3:0]        r_outstanding;
  logic [PKT_W-1:0]  r_rsp_pkt;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_err;

  logic [N_REQ-1:0]  w_grant_oh;
  logic              w_found;
  logic [ID_W-1:0]   w_grant_id;
  logic [PKT_W-1:0]  w_grant_pkt;
  logic              w_can_grant;
  logic              w_grant;
  logic              w_req_xfer;
  logic              w_rsp_xfer;
  logic [ID_W-1:0]   w_rsp_id;
  logic              w_rsp_routed;
  logic [N_REQ-1:0]  w_rsp_sel;
  logic              w_rsp_done;

  // Round-robin search: first pass above last_grant, second pass wraps to 0..last_grant.
  always_comb begin
    w_grant_oh = '0;
    w_found    = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!w_found && (i > int'(r_last_grant)) && i_req_valid[i]) begin
        w_grant_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!w_found && (i <= int'(r_last_grant)) && i_req_valid[i]) begin
        w_grant_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  // Encode the one-hot grant into an id and select the matching packet slice.
  always_comb begin
    w_grant_id  = '0;
    w_grant_pkt = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_grant_oh[i]) begin
        w_grant_id  = ID_W'(i);
        w_grant_pkt = i_req_pkt[i*PKT_W +: PKT_W];
      end
    end
  end

  // Reset is folded in so no strobe escapes while rst_n is held low.
  assign w_can_grant = i_rst_n && (r_req_state == StIdle) && (r_outstanding < 4'(MAX_OUT));
  assign w_grant     = w_can_grant && w_found;
  assign w_req_xfer  = o_out_req_valid && i_out_req_ready;
  assign w_rsp_xfer  = i_out_rsp_valid && o_out_rsp_ready;

  // Request FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_req_state <= StIdle;
    else          r_req_state <= w_req_state_next;
  end

  // Request FSM next state: one accept, then hold until the shared port takes it.
  always_comb begin
    w_req_state_next = r_req_state;
    unique case (r_req_state)
      StIdle:  if (w_grant)         w_req_state_next = StSend;
      StSend:  if (i_out_req_ready) w_req_state_next = StIdle;
      default:                      w_req_state_next = StIdle;
    endcase
  end

  // Request FSM outputs.
  always_comb begin
    o_req_ready     = w_grant ? w_grant_oh : '0;
    o_out_req_valid = (r_req_state == StSend);
    o_out_req_pkt   = (r_req_state == StSend) ? r_req_pkt : '0;
  end

  // Capture the granted packet and remember who won for the next search.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_pkt    <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
    end else if (w_grant) begin
      r_req_pkt    <= w_grant_pkt;
      r_last_grant <= w_grant_id;
    end
  end

  // In-flight counter; saturates at both ends, simultaneous inc/dec cancel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outstanding <= '0;
    end else if (w_req_xfer && !w_rsp_xfer) begin
      if (r_outstanding < 4'(MAX_OUT)) r_outstanding <= r_outstanding + 4'd1;
    end else if (w_rsp_xfer && !w_req_xfer) begin
      if (r_outstanding != 4'd0) r_outstanding <= r_outstanding - 4'd1;
    end
  end

  assign o_outstanding = r_outstanding;

  assign w_rsp_id     = i_out_rsp_pkt[ID_W-1:0];
  assign w_rsp_routed = (int'(w_rsp_id) < int'(N_REQ));

  // One-hot select of the held response's destination.
  always_comb begin
    w_rsp_sel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_rsp_sel[i] = (int'(r_rsp_id) == i);
    end
  end

  assign w_rsp_done = |(w_rsp_sel & i_rsp_ready);

  // Response FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rsp_state <= StRIdle;
    else          r_rsp_state <= w_rsp_state_next;
  end

  // Response FSM next state: routed ids are held until the requester accepts.
  always_comb begin
    w_rsp_state_next = r_rsp_state;
    unique case (r_rsp_state)
      StRIdle: if (w_rsp_xfer && w_rsp_routed) w_rsp_state_next = StRHold;
      StRHold: if (w_rsp_done)                 w_rsp_state_next = StRIdle;
      default:                                 w_rsp_state_next = StRIdle;
    endcase
  end

  // Response FSM outputs.
  always_comb begin
    o_out_rsp_ready = i_rst_n && (r_rsp_state == StRIdle);
    o_rsp_valid     = (r_rsp_state == StRHold) ? w_rsp_sel : '0;
    o_rsp_pkt       = (r_rsp_state == StRHold) ? r_rsp_pkt : '0;
    o_err_unrouted  = r_err;
  end

  // Register the accepted response; unroutable ids only raise a one-cycle error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_pkt <= '0;
      r_rsp_id  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_rsp_xfer && !w_rsp_routed;
      if (w_rsp_xfer) begin
        r_rsp_pkt <= i_out_rsp_pkt;
        r_rsp_id  <= w_rsp_id;
      end
    end
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of core-internal requesters; requester i carries source id i (0 = fetch).
REQ-002 Parameter PKT_W, default 64: bus packet width; bits [ID_W-1:0] hold source.within_core_id.
REQ-003 Parameter ID_W, default 2: source id field width; 2^ID_W SHALL be >= N_REQ.
REQ-004 Parameter MAX_OUT, default 4: maximum outstanding requests on the shared port, 1..15.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  N_REQ  per-requester request present.
REQ-008 req_pkt  input  N_REQ*PKT_W  per-requester request packets; requester i occupies slice i.
REQ-009 req_ready  output  N_REQ  one-hot request accept strobe.
REQ-010 out_req_valid  output  1  request to shared memory bus.
REQ-011 out_req_pkt  output  PKT_W  request packet to shared bus.
REQ-012 out_req_ready  input  1  shared bus accepts request.
REQ-013 out_rsp_valid  input  1  response from shared bus.
REQ-014 out_rsp_pkt  input  PKT_W  response packet.
REQ-015 out_rsp_ready  output  1  arbiter accepts response.
REQ-016 rsp_valid  output  N_REQ  one-hot response delivery to requester.
REQ-017 rsp_pkt  output  PKT_W  response packet, shared by all requesters.
REQ-018 rsp_ready  input  N_REQ  requester accepts response.
REQ-019 outstanding  output  4  current in-flight request count.
REQ-020 err_unrouted  output  1  one-cycle pulse when a response id >= N_REQ is dropped.

Function
REQ-021 Request FSM states: IDLE, SEND; transfer on a port occurs when valid and ready are both high on a clock edge.
REQ-022 In IDLE with outstanding < MAX_OUT, SHALL grant the first requester with req_valid high, searching round-robin from (last_grant+1) mod N_REQ; assert req_ready[grant] combinationally that cycle, capture req_pkt slice into a register, update last_grant, go to SEND.
REQ-023 In IDLE with outstanding == MAX_OUT, req_ready SHALL be all zero.
REQ-024 In SEND, out_req_valid SHALL be 1 with the captured packet, held stable until out_req_ready; on transfer return to IDLE; request latency = 1 cycle from accept to out_req_valid.
REQ-025 Consequently at most one grant per two cycles; req_ready SHALL be 0 in SEND.
REQ-026 outstanding SHALL increment on out_req transfer, decrement on out_rsp transfer; both in same cycle leaves it unchanged; it SHALL never exceed MAX_OUT nor wrap below 0 (response at 0 is still routed, count stays 0).
REQ-027 Response FSM states: R_IDLE, R_HOLD; in R_IDLE out_rsp_ready = 1; on transfer register packet, decode id from bits [ID_W-1:0].
REQ-028 If id < N_REQ, go to R_HOLD, drive rsp_valid[id]=1 with rsp_pkt = registered packet until rsp_ready[id]; then R_IDLE.
REQ-029 If id >= N_REQ, packet dropped, err_unrouted pulses 1 cycle later, stay in R_IDLE.
REQ-030 out_rsp_ready SHALL be 0 in R_HOLD; request and response FSMs operate independently in the same cycle.
REQ-031 last_grant wrap: after grant to N_REQ-1, search starts at 0.

Reset
REQ-032 While rst_n low: request FSM = IDLE, response FSM = R_IDLE, last_grant = N_REQ-1 (so requester 0 has first priority), outstanding = 0, captured packets = 0.
REQ-033 Reset outputs: req_ready = 0 while asserted, out_req_valid = 0, out_req_pkt = 0, out_rsp_ready = 0 while asserted, rsp_valid = 0, rsp_pkt = 0, err_unrouted = 0.
REQ-034 Reset asserted mid-SEND or mid-R_HOLD SHALL abandon the packet immediately; no partial transfer after deassertion.

Verification
REQ-035 All three req_valid high continuously, out_req_ready = 1 -> out_req_pkt ids sequence 0,1,2,0,1,2; one grant every 2 cycles.
REQ-036 MAX_OUT=4, no responses, requester 1 streaming -> exactly 4 transfers, outstanding = 4, req_ready stays 0 until a response arrives.
REQ-037 Response with id 0, rsp_ready[0] held low 3 cycles -> rsp_valid[0] held 4 cycles, out_rsp_ready 0 during hold, packet stable.
REQ-038 Response id 3 (N_REQ=3) -> no rsp_valid, err_unrouted single pulse, outstanding decremented.
REQ-039 out_req transfer and out_rsp transfer in the same cycle at outstanding = 2 -> outstanding stays 2.
REQ-040 rst_n pulled low while in SEND with out_req_ready = 0 -> out_req_valid drops asynchronously; after release, first grant goes to requester 0.
